// File: rtl/cordic_pkg.sv
// cordic_pkg: atan table, angle-constant helper, mode encoding and gain for the CORDIC pipeline
package cordic_pkg;

    typedef enum logic {CORDIC_ROT = 1'b0, CORDIC_VEC = 1'b1} cordic_mode_e;

    localparam real CORDIC_K = 1.646760258;

    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    function automatic logic [31:0] atan_val(input int i, input int bw);
        logic [32:0] r;
        r = {1'b0, ATAN_TABLE[i[4:0]]};
        if (bw < 32) r = r + (33'd1 << (31 - bw));
        return 32'(r >> (32 - bw));
    endfunction

endpackage

// File: rtl/cordic_pipe_if.sv
// cordic_pipe_if: valid/ready sample and result channels of the CORDIC pipeline
interface cordic_pipe_if #(
    parameter int BIT_WIDTH = 16,
    parameter int TAG_WIDTH = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_mode;
    logic signed [BIT_WIDTH-1:0] in_x;
    logic signed [BIT_WIDTH-1:0] in_y;
    logic signed [BIT_WIDTH-1:0] in_angle;
    logic [TAG_WIDTH-1:0]        in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_mode;
    logic signed [BIT_WIDTH+1:0] out_x;
    logic signed [BIT_WIDTH+1:0] out_y;
    logic signed [BIT_WIDTH-1:0] out_angle;
    logic [TAG_WIDTH-1:0]        out_tag;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_angle, in_tag, out_ready,
        input  in_ready, out_valid, out_mode, out_x, out_y, out_angle, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_angle, in_tag, out_ready,
        output in_ready, out_valid, out_mode, out_x, out_y, out_angle, out_tag
    );
endinterface

// File: rtl/cordic_pipe_stage.sv
// cordic_pipe_stage: one registered CORDIC micro-rotation with global enable
module cordic_pipe_stage
    import cordic_pkg::*;
#(
    parameter int          BIT_WIDTH = 16,
    parameter int          TAG_WIDTH = 4,
    parameter int          SHIFT     = 0,
    parameter logic [31:0] ATAN      = 32'h0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic                        in_mode,
    input  logic signed [BIT_WIDTH+1:0] in_x,
    input  logic signed [BIT_WIDTH+1:0] in_y,
    input  logic signed [BIT_WIDTH-1:0] in_z,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    output logic                        out_valid,
    output logic                        out_mode,
    output logic signed [BIT_WIDTH+1:0] out_x,
    output logic signed [BIT_WIDTH+1:0] out_y,
    output logic signed [BIT_WIDTH-1:0] out_z,
    output logic [TAG_WIDTH-1:0]        out_tag
);
    localparam logic signed [BIT_WIDTH-1:0] A = ATAN[BIT_WIDTH-1:0];

    logic                        pos;
    logic signed [BIT_WIDTH+1:0] xs;
    logic signed [BIT_WIDTH+1:0] ys;

    assign pos = (in_mode == CORDIC_VEC) ? in_y[BIT_WIDTH+1] : ~in_z[BIT_WIDTH-1];
    assign xs  = in_x >>> SHIFT;
    assign ys  = in_y >>> SHIFT;

    // rotate by +/-atan(2^-SHIFT) toward z=0 (rotation) or y=0 (vectoring); hold on stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_x     <= pos ? in_x - ys : in_x + ys;
            out_y     <= pos ? in_y + xs : in_y - xs;
            out_z     <= pos ? in_z - A : in_z + A;
            out_tag   <= in_tag;
        end
    end
endmodule

// File: rtl/cordic_pipe.sv
// cordic_pipe: pre-rotation register followed by STAGES registered CORDIC micro-rotations
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int STAGES    = BIT_WIDTH,
    parameter int TAG_WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    cordic_pipe_if.slave bus
);
    logic                        en;
    logic                        flip;
    logic                        vec;
    logic signed [BIT_WIDTH+1:0] ex;
    logic signed [BIT_WIDTH+1:0] ey;

    logic                        pv, pm;
    logic signed [BIT_WIDTH+1:0] px, py;
    logic signed [BIT_WIDTH-1:0] pz;
    logic [TAG_WIDTH-1:0]        pt;

    logic                        v [0:STAGES];
    logic                        m [0:STAGES];
    logic signed [BIT_WIDTH+1:0] x [0:STAGES];
    logic signed [BIT_WIDTH+1:0] y [0:STAGES];
    logic signed [BIT_WIDTH-1:0] z [0:STAGES];
    logic [TAG_WIDTH-1:0]        t [0:STAGES];

    assign en           = ~v[STAGES] | bus.out_ready;
    assign bus.in_ready = en;

    assign vec  = (bus.in_mode == CORDIC_VEC);
    assign ex   = {{2{bus.in_x[BIT_WIDTH-1]}}, bus.in_x};
    assign ey   = {{2{bus.in_y[BIT_WIDTH-1]}}, bus.in_y};
    assign flip = vec ? bus.in_x[BIT_WIDTH-1] : bus.in_angle[BIT_WIDTH-1] ^ bus.in_angle[BIT_WIDTH-2];

    // fold the input into the right half-plane by a pi rotation so the stages converge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv <= 1'b0;
            pm <= 1'b0;
            px <= '0;
            py <= '0;
            pz <= '0;
            pt <= '0;
        end else if (en) begin
            pv <= bus.in_valid;
            pm <= bus.in_mode;
            px <= flip ? -ex : ex;
            py <= flip ? -ey : ey;
            pz <= vec ? {flip, {(BIT_WIDTH-1){1'b0}}}
                      : {bus.in_angle[BIT_WIDTH-1] ^ flip, bus.in_angle[BIT_WIDTH-2:0]};
            pt <= bus.in_tag;
        end
    end

    assign v[0] = pv;
    assign m[0] = pm;
    assign x[0] = px;
    assign y[0] = py;
    assign z[0] = pz;
    assign t[0] = pt;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_pipe_stage #(
            .BIT_WIDTH(BIT_WIDTH),
            .TAG_WIDTH(TAG_WIDTH),
            .SHIFT    (i),
            .ATAN     (atan_val(i, BIT_WIDTH))
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en),
            .in_valid (v[i]),
            .in_mode  (m[i]),
            .in_x     (x[i]),
            .in_y     (y[i]),
            .in_z     (z[i]),
            .in_tag   (t[i]),
            .out_valid(v[i+1]),
            .out_mode (m[i+1]),
            .out_x    (x[i+1]),
            .out_y    (y[i+1]),
            .out_z    (z[i+1]),
            .out_tag  (t[i+1])
        );
    end

    assign bus.out_valid = v[STAGES];
    assign bus.out_mode  = m[STAGES];
    assign bus.out_x     = x[STAGES];
    assign bus.out_y     = y[STAGES];
    assign bus.out_angle = z[STAGES];
    assign bus.out_tag   = t[STAGES];
endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: directed checks of the CORDIC pipeline at 16 bits / 16 stages
module tb_cordic_pipe;
    localparam int W = 16;
    localparam int S = 16;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cordic_pipe_if #(.BIT_WIDTH(W), .TAG_WIDTH(T)) bus ();

    cordic_pipe #(.BIT_WIDTH(W), .STAGES(S), .TAG_WIDTH(T)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
        logic ok;
        ok = (obs - exp <= tol) && (exp - obs <= tol);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic chk_ang(input string tag, input logic [15:0] obs, input int exp);
        logic signed [15:0] d;
        logic [15:0] e;
        e = exp[15:0];
        d = obs - e;
        chk_near(tag, longint'(exp) + longint'(d), longint'(exp), 6);
    endtask

    task automatic drive(input int k, input logic vld);
        bus.in_valid = vld;
        bus.in_mode  = k[0];
        bus.in_x     = 16'(1000 + 37 * k);
        bus.in_y     = '0;
        bus.in_angle = 16'(k * 1024);
        bus.in_tag   = k[3:0];
    endtask

    task automatic run_one(input logic md, input int xi, input int yi, input int ai, input int tg,
                           output longint ox, output longint oy, output logic [15:0] oa,
                           output int lat, output int om, output int ot);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = md;
        bus.in_x      = xi[15:0];
        bus.in_y      = yi[15:0];
        bus.in_angle  = ai[15:0];
        bus.in_tag    = tg[3:0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ox = longint'(bus.out_x);
        oy = longint'(bus.out_y);
        oa = bus.out_angle;
        om = int'(bus.out_mode);
        ot = int'(bus.out_tag);
    endtask

    task automatic stream(input string nm, input int n, input int stall_at);
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        int   first = 0;
        int   stall = 0;
        int   gaps = 0;
        logic acc;
        logic signed [17:0] hx;
        logic [3:0] ht;
        bus.out_ready = 1'b1;
        drive(0, 1'b1);
        #1;
        acc = bus.in_valid && bus.in_ready;
        while (got < n && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
            if (stall_at >= 0 && got == stall_at && stall == 0) begin
                stall = 1;
                hx = bus.out_x;
                ht = bus.out_tag;
            end
            bus.out_ready = !(stall >= 1 && stall <= 5);
            drive(sent, sent < n);
            #1;
            if (stall >= 1 && stall <= 5) begin
                chk({nm, "_stall_ready"}, bus.in_ready, 0);
                chk({nm, "_stall_x"}, bus.out_x, hx);
                chk({nm, "_stall_tag"}, bus.out_tag, ht);
                stall++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (got == 0) first = cyc;
                chk({nm, "_tag"}, bus.out_tag, got % 16);
                chk({nm, "_mode"}, bus.out_mode, got % 2);
                got++;
            end else if (got > 0 && got < n && stall_at < 0) begin
                gaps++;
            end
            acc = bus.in_valid && bus.in_ready;
        end
        chk({nm, "_count"}, got, n);
        chk({nm, "_sent"}, sent, n);
        if (stall_at < 0) begin
            chk({nm, "_first_lat"}, first, S + 1);
            chk({nm, "_gaps"}, gaps, 0);
        end else begin
            chk({nm, "_stall_len"}, stall, 6);
        end
    endtask

    initial begin
        longint ox, oy;
        logic [15:0] oa;
        int lat, om, ot, stale;

        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_x      = 16'sd1234;
        bus.in_y      = 16'sd567;
        bus.in_angle  = 16'h1000;
        bus.in_tag    = 4'h5;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_x", bus.out_x, 0);
        chk("rst_out_y", bus.out_y, 0);
        chk("rst_out_angle", bus.out_angle, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_mode", bus.out_mode, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        run_one(1'b0, 9949, 0, 16'h2000, 1, ox, oy, oa, lat, om, ot);
        chk("r45_lat", lat, S + 1);
        chk_near("r45_x", ox, 11585, 6);
        chk_near("r45_y", oy, 11585, 6);
        chk_ang("r45_angle", oa, 0);
        chk("r45_tag", ot, 1);
        chk("r45_mode", om, 0);

        run_one(1'b0, 9949, 0, 16'h8000, 2, ox, oy, oa, lat, om, ot);
        chk_near("r180_x", ox, -16384, 6);
        chk_near("r180_y", oy, 0, 6);
        chk("r180_tag", ot, 2);

        run_one(1'b0, 9949, 0, 16'h6000, 3, ox, oy, oa, lat, om, ot);
        chk_near("r135_x", ox, -11585, 6);
        chk_near("r135_y", oy, 11585, 6);

        run_one(1'b0, -32768, 0, 16'h8000, 4, ox, oy, oa, lat, om, ot);
        chk_near("rneg_x", ox, 53961, 10);
        chk_near("rneg_y", oy, 0, 10);

        run_one(1'b1, -3000, 4000, 0, 5, ox, oy, oa, lat, om, ot);
        chk_near("vq2_x", ox, 8234, 6);
        chk_near("vq2_y", oy, 0, 6);
        chk_ang("vq2_angle", oa, 16'h5A39);
        chk("vq2_mode", om, 1);
        chk("vq2_lat", lat, S + 1);

        run_one(1'b1, 3000, 4000, 0, 6, ox, oy, oa, lat, om, ot);
        chk_near("vq1_x", ox, 8234, 6);
        chk_near("vq1_y", oy, 0, 6);
        chk_ang("vq1_angle", oa, 9672);

        run_one(1'b1, -3000, -4000, 0, 7, ox, oy, oa, lat, om, ot);
        chk_near("vq3_x", ox, 8234, 6);
        chk_ang("vq3_angle", oa, -23097);

        @(posedge clk);
        #1;
        stream("b2b", 20, -1);
        repeat (3) @(posedge clk);
        #1;
        stream("stall", 30, 3);
        repeat (3) @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b1);
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("inflight_valid", bus.out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_x", bus.out_x, 0);
        chk("arst_out_tag", bus.out_tag, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale++;
        end
        chk("arst_stale", stale, 0);

        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_one(1'b0, 9949, 0, 16'h2000, 9, ox, oy, oa, lat, om, ot);
        chk("rel_lat", lat, S + 1);
        chk_near("rel_x", ox, 11585, 6);
        chk("rel_tag", ot, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
